fifo_reader: RTL and testbench



---
 rtl/fifo_reader.sv | 88 ++++++++
 tb/tb_fifo_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: drains a show-ahead FIFO read port into a valid/ready stream
// through a 2-entry output buffer, keeping a delivered-word count and checksum.
module fifo_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [DATA_WIDTH-1:0]  fifo_data_out,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [DATA_WIDTH-1:0]  checksum,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_next;
  logic [1:0]            occ, occ_next;
  logic [DATA_WIDTH-1:0] head_q, tail_q;
  logic                  push, pop;

  // Read/handshake decode; reads depend on registered occupancy only
  always_comb begin
    fifo_rd_en = rst_n & enable & ~fifo_empty & (occ != 2'd2);
    push       = fifo_rd_en;
    m_valid    = (occ != 2'd0);
    pop        = m_valid & m_ready;
    occ_next   = occ + {1'b0, push} - {1'b0, pop};
    m_data     = head_q;
    busy       = (state != IDLE);
  end

  // Output buffer: head is the presented word, tail the second entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ <= occ_next;
      if (push && (occ == 2'd0 || (occ == 2'd1 && pop)))
        head_q <= fifo_data_out;
      else if (push && occ == 2'd1)
        tail_q <= fifo_data_out;
      else if (pop && occ == 2'd2)
        head_q <= tail_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state; enable takes precedence over draining to idle
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = (occ_next == 2'd0) ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)                 state_next = RUN;
        else if (occ_next == 2'd0)  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Delivered-word counter (saturating) and checksum (wrapping); clear wins over pop
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      word_count <= '0;
      checksum   <= '0;
    end else if (pop) begin
      if (word_count != '1) word_count <= word_count + 1'b1;
      checksum <= checksum + head_q;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fifo_reader;

  localparam int DW = 8;
  localparam int CW = 4;   // narrow counter so saturation is reachable

  logic          clk = 1'b0;
  logic          rst_n, enable, clear, m_ready;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic [CW-1:0] word_count;
  logic [DW-1:0] checksum;
  logic          busy;

  fifo_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .word_count(word_count), .checksum(checksum), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] src[$];     // source FIFO contents
  logic [DW-1:0] mq[$];      // words held by the block
  logic [DW-1:0] got[$];     // words actually handed over by the DUT
  int            m_cnt;
  logic [DW-1:0] m_cs;
  logic          m_busy;
  logic [DW-1:0] m_last;
  logic          last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    fifo_empty    = (src.size() == 0);
    fifo_data_out = (src.size() != 0) ? src[0] : '0;
  endtask

  task automatic model_reset();
    mq.delete(); m_cnt = 0; m_cs = '0; m_busy = 1'b0; m_last = '0;
  endtask

  // One clock: check read strobe before the edge, advance model, check outputs after
  task automatic step();
    logic exp_rd;
    logic [DW-1:0] w;
    drive_src();
    #1;
    exp_rd = rst_n && enable && (src.size() != 0) && (mq.size() < 2);
    chk("rd_en", fifo_rd_en, exp_rd);
    last_rd = fifo_rd_en;
    if (rst_n && m_valid && m_ready) got.push_back(m_data);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (mq.size() != 0 && m_ready) begin
        w = mq.pop_front();
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        m_cs = m_cs + w;
      end
      if (clear) begin m_cnt = 0; m_cs = '0; end
      if (exp_rd) mq.push_back(src.pop_front());
      m_busy = enable || (m_busy && mq.size() != 0);
      if (mq.size() != 0) m_last = mq[0];
    end
    drive_src();
    chk("m_valid", m_valid, mq.size() != 0);
    chk("m_data", m_data, m_last);
    chk("word_count", word_count, m_cnt);
    chk("checksum", checksum, m_cs);
    chk("busy", busy, m_busy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; m_ready = 1'b0;
    src.delete(); got.delete();
    step(); step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          exp_rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_cnt;
    logic [DW-1:0] exp_cs;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int   rd_cnt;
    logic [DW-1:0] exp_words[$];

    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; m_ready = 1'b0;
    last_rd = 1'b0;
    model_reset();
    drive_src();

    // Reset state
    do_reset();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);

    // Streaming 0x11..0x44 with m_ready=1
    tbl[0] = '{1'b1, 1'b1, 8'h11, 0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 8'h22, 1, 8'h11};
    tbl[2] = '{1'b1, 1'b1, 8'h33, 2, 8'h33};
    tbl[3] = '{1'b1, 1'b1, 8'h44, 3, 8'h66};
    tbl[4] = '{1'b0, 1'b0, 8'h44, 4, 8'hAA};
    src = '{8'h11, 8'h22, 8'h33, 8'h44};
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("tbl%0d_rd", i), last_rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_data", i), m_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_cnt", i), word_count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_cs", i), checksum, tbl[i].exp_cs);
    end

    // Backpressure: 5 stalled cycles read exactly two words
    do_reset();
    src = '{8'h01, 8'h02, 8'h03, 8'h04};
    enable = 1'b1; m_ready = 1'b0; rd_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      rd_cnt += int'(last_rd);
      chk("stall_data", m_data, 8'h01);
    end
    chk("stall_reads", rd_cnt, 2);
    m_ready = 1'b1;
    for (int i = 0; i < 12 && got.size() < 4; i++) step();
    exp_words = '{8'h01, 8'h02, 8'h03, 8'h04};
    chk("stall_count", got.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("stall_order", (i < got.size()) ? got[i] : 8'hXX, exp_words[i]);

    // m_ready toggling against 8 words
    do_reset();
    exp_words.delete();
    for (int i = 0; i < 8; i++) begin
      src.push_back(8'hA0 + 8'(i));
      exp_words.push_back(8'hA0 + 8'(i));
    end
    enable = 1'b1;
    for (int i = 0; i < 40 && got.size() < 8; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    step();
    chk("toggle_count", word_count, 8);
    chk("toggle_got", got.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("toggle_order", (i < got.size()) ? got[i] : 8'hXX, exp_words[i]);

    // Enable drop with two buffered words -> DRAIN, then drain to IDLE
    do_reset();
    src = '{8'h51, 8'h52, 8'h53, 8'h54};
    enable = 1'b1; m_ready = 1'b0;
    step(); step();
    enable = 1'b0;
    step();
    chk("drain_busy", busy, 1);
    chk("drain_rd", last_rd, 0);
    step();
    chk("drain_hold_rd", last_rd, 0);
    m_ready = 1'b1;
    step(); step();
    chk("drain_got", got.size(), 2);
    chk("drain_idle", busy, 0);
    chk("drain_valid", m_valid, 0);

    // Checksum wrap, then clear colliding with a pop
    do_reset();
    src = '{8'hFF, 8'h02, 8'h05};
    enable = 1'b1; m_ready = 1'b1;
    step(); step(); step();
    chk("wrap_cs", checksum, 8'h01);
    chk("wrap_cnt", word_count, 2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_cnt", word_count, 0);
    chk("clear_cs", checksum, 0);

    // Reset mid-stream with two buffered words
    do_reset();
    src = '{8'h61, 8'h62, 8'h63, 8'h64};
    enable = 1'b1; m_ready = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    chk("midrst_valid", m_valid, 0);
    chk("midrst_cnt", word_count, 0);
    step();
    chk("midrst_rd", last_rd, 0);
    rst_n = 1'b1;
    step();
    chk("resume_data", m_data, 8'h63);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst_n   = ($urandom_range(99) != 0);
      enable  = ($urandom_range(3) != 0);
      m_ready = ($urandom_range(2) != 0);
      clear   = ($urandom_range(79) == 0);
      if ($urandom_range(1) == 1 && src.size() < 6) src.push_back(DW'($urandom));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
